uart_tx_sequencer: RTL and testbench

Packetizes PMT timebin count words onto the shared byte-wide UART transmitter. Two requesters share the UART: port A (count stream) and port B (status/auxiliary). The block round-robin arbitrates, sends a header byte plus the word MSB-first, and paces each byte on the UART's done pulse. It sits between the counting logic and the UART transmit interface (`transmit` / `tx_byte` / `is_transmitting` / `tx_Done`).

---
 rtl/uart_tx_sequencer.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sequencer.sv
// Two-port round-robin packetizer for a byte-wide UART: header byte, then the word MSB-first.
// Define UART_SEQ_CHECKSUM_EN to append an XOR checksum byte to every packet.
module uart_tx_sequencer #(
    parameter int unsigned WORD_BYTES = 4,
    parameter logic [7:0]  HDR_A      = 8'hA5,
    parameter logic [7:0]  HDR_B      = 8'h5A
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_a,
    input  logic [8*WORD_BYTES-1:0] data_a,
    output logic                    ack_a,
    input  logic                    req_b,
    input  logic [8*WORD_BYTES-1:0] data_b,
    output logic                    ack_b,
    output logic                    uart_transmit,
    output logic [7:0]              uart_tx_byte,
    input  logic                    uart_busy,
    input  logic                    uart_tx_done,
    output logic                    busy,
    output logic                    pkt_done,
    output logic                    grant_b
);

    localparam int unsigned DW = 8 * WORD_BYTES;
    localparam int unsigned IW = $clog2(WORD_BYTES + 2);
`ifdef UART_SEQ_CHECKSUM_EN
    localparam int unsigned LastIdx = WORD_BYTES + 1;
`else
    localparam int unsigned LastIdx = WORD_BYTES;
`endif
    localparam logic [IW-1:0] Last = IW'(LastIdx);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e          state_q, state_d;
    logic [DW+7:0]   sr_q, sr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            last_b_q, last_b_d;
    logic            grant_b_q, grant_b_d;
    logic            ack_a_q, ack_a_d;
    logic            ack_b_q, ack_b_d;
    logic            tx_q, tx_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic            pkt_done_q, pkt_done_d;
    logic            busy_q, busy_d;
    logic            pick_b;
    logic [7:0]      fill;

`ifdef UART_SEQ_CHECKSUM_EN
    logic [7:0] chk_q, chk_d;

    function automatic logic [7:0] xor_bytes(input logic [DW-1:0] w);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
            x = x ^ w[8*i +: 8];
        end
        return x;
    endfunction
`endif

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        idx_d      = idx_q;
        last_b_d   = last_b_q;
        grant_b_d  = grant_b_q;
        ack_a_d    = 1'b0;
        ack_b_d    = 1'b0;
        tx_d       = 1'b0;
        tx_byte_d  = tx_byte_q;
        pkt_done_d = 1'b0;
        pick_b     = 1'b0;
`ifdef UART_SEQ_CHECKSUM_EN
        chk_d      = chk_q;
        fill       = chk_q;
`else
        fill       = 8'h00;
`endif

        case (state_q)
            StIdle: begin
                idx_d = '0;
                if (req_a || req_b) begin
                    // On a tie, serve whichever port was not served last.
                    pick_b    = req_b && (!req_a || !last_b_q);
                    sr_d      = pick_b ? {HDR_B, data_b} : {HDR_A, data_a};
`ifdef UART_SEQ_CHECKSUM_EN
                    chk_d     = pick_b ? (HDR_B ^ xor_bytes(data_b))
                                       : (HDR_A ^ xor_bytes(data_a));
`endif
                    ack_a_d   = !pick_b;
                    ack_b_d   = pick_b;
                    grant_b_d = pick_b;
                    last_b_d  = pick_b;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                if (!uart_busy) begin
                    tx_d      = 1'b1;
                    tx_byte_d = sr_q[DW+7 -: 8];
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (uart_tx_done) begin
                    if (idx_q == Last) begin
                        state_d = StDone;
                    end else begin
                        // Checksum enters at the bottom and surfaces after the data bytes.
                        idx_d   = idx_q + IW'(1);
                        sr_d    = {sr_q[DW-1:0], fill};
                        state_d = StIssue;
                    end
                end
            end
            StDone: begin
                pkt_done_d = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            sr_q       <= '0;
            idx_q      <= '0;
            last_b_q   <= 1'b1;
            grant_b_q  <= 1'b0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            tx_q       <= 1'b0;
            tx_byte_q  <= 8'h00;
            pkt_done_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_SEQ_CHECKSUM_EN
            chk_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            idx_q      <= idx_d;
            last_b_q   <= last_b_d;
            grant_b_q  <= grant_b_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            tx_q       <= tx_d;
            tx_byte_q  <= tx_byte_d;
            pkt_done_q <= pkt_done_d;
            busy_q     <= busy_d;
`ifdef UART_SEQ_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    assign ack_a         = ack_a_q;
    assign ack_b         = ack_b_q;
    assign uart_transmit = tx_q;
    assign uart_tx_byte  = tx_byte_q;
    assign busy          = busy_q;
    assign pkt_done      = pkt_done_q;
    assign grant_b       = grant_b_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer: directed packets, a UART model, and a byte monitor.
module tb_uart_tx_sequencer;

    localparam int unsigned WB = 4;
    localparam int unsigned DW = 8 * WB;
`ifdef UART_SEQ_CHECKSUM_EN
    localparam int PKT_LEN = WB + 2;
`else
    localparam int PKT_LEN = WB + 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_a, req_b;
    logic [DW-1:0] data_a, data_b;
    logic          ack_a, ack_b;
    logic          uart_transmit;
    logic [7:0]    uart_tx_byte;
    logic          uart_busy, uart_tx_done;
    logic          busy, pkt_done, grant_b;

    logic model_busy, model_done, force_busy, stray_done;
    int   model_cnt;

    logic [7:0] exp_q[$];
    bit         gb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_ack_a  = 0;
    int n_ack_b  = 0;
    int n_pkt    = 0;
    int n_tx     = 0;
    int pos      = 0;

    assign uart_busy    = model_busy | force_busy;
    assign uart_tx_done = model_done | stray_done;

    always #5 clk = ~clk;

    uart_tx_sequencer #(.WORD_BYTES(WB), .HDR_A(8'hA5), .HDR_B(8'h5A)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_a         (req_a),
        .data_a        (data_a),
        .ack_a         (ack_a),
        .req_b         (req_b),
        .data_b        (data_b),
        .ack_b         (ack_b),
        .uart_transmit (uart_transmit),
        .uart_tx_byte  (uart_tx_byte),
        .uart_busy     (uart_busy),
        .uart_tx_done  (uart_tx_done),
        .busy          (busy),
        .pkt_done      (pkt_done),
        .grant_b       (grant_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected bytes for one packet: header, word MSB-first, hand-computed checksum.
    task automatic push_pkt(input bit is_b, input logic [DW-1:0] w, input logic [7:0] chk);
        exp_q.push_back(is_b ? 8'h5A : 8'hA5);
        for (int i = WB - 1; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
`ifdef UART_SEQ_CHECKSUM_EN
        exp_q.push_back(chk);
`else
        if (chk === 8'hxx) $display("note: unknown checksum operand");
`endif
        gb_q.push_back(is_b);
    endtask

    task automatic request(input bit is_b, input logic [DW-1:0] w, input bit hold);
        bit got;
        got = 1'b0;
        if (is_b) begin data_b = w; req_b = 1'b1; end
        else begin data_a = w; req_a = 1'b1; end
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ((is_b ? ack_b : ack_a) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check(is_b ? "ack_b_seen" : "ack_a_seen", got, 1);
        if (!hold) begin
            if (is_b) req_b = 1'b0;
            else req_a = 1'b0;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #1 rst = 1'b1;
        req_a = 1'b0; req_b = 1'b0; force_busy = 1'b0; stray_done = 1'b0;
        exp_q.delete(); gb_q.delete();
        n_ack_a = 0; n_ack_b = 0; n_pkt = 0; n_tx = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic finish_test(input string name, input int na, input int nb, input int np);
        for (int i = 0; i < 4000 && n_pkt < np; i++) begin
            @(negedge clk);
            #1;
        end
        repeat (5) @(negedge clk);
        #1;
        check({name, "_pkt_done"}, n_pkt, np);
        check({name, "_ack_a"}, n_ack_a, na);
        check({name, "_ack_b"}, n_ack_b, nb);
        check({name, "_tx_count"}, n_tx, np * PKT_LEN);
        check({name, "_queue_left"}, exp_q.size(), 0);
        check({name, "_busy_idle"}, busy, 0);
    endtask

    // UART model: done pulse 20 cycles after each transmit, busy in between.
    initial begin
        model_busy = 1'b0;
        model_done = 1'b0;
        model_cnt  = 0;
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            if (model_cnt > 0) begin
                model_cnt--;
                if (model_cnt == 0) begin
                    model_done = 1'b1;
                    model_busy = 1'b0;
                end
            end else if (uart_transmit === 1'b1 && !rst) begin
                model_cnt  = 20;
                model_busy = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every transmit pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pos = 0;
            end else begin
                if (ack_a === 1'b1) n_ack_a++;
                if (ack_b === 1'b1) n_ack_b++;
                if (pkt_done === 1'b1) n_pkt++;
                if (uart_transmit === 1'b1) begin
                    n_tx++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_tx: got byte %02h, expected no transmit",
                                 uart_tx_byte);
                    end else begin
                        check("tx_byte", uart_tx_byte, exp_q.pop_front());
                        if (pos == 0 && gb_q.size() != 0) check("grant_b", grant_b, gb_q.pop_front());
                        pos = (pos + 1 == PKT_LEN) ? 0 : pos + 1;
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_tx;
        bit found;
        int seen;
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0;
        force_busy = 1'b0; stray_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ack_a", ack_a, 0);
        check("rst_ack_b", ack_b, 0);
        check("rst_transmit", uart_transmit, 0);
        check("rst_tx_byte", uart_tx_byte, 8'h00);
        check("rst_pkt_done", pkt_done, 0);
        check("rst_grant_b", grant_b, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single A packet.
        push_pkt(0, 32'h12345678, 8'hAD);
        request(0, 32'h12345678, 0);
        finish_test("single", 1, 0, 1);

        // Tie after reset: A first, then B.
        reset_dut();
        push_pkt(0, 32'h12345678, 8'hAD);
        push_pkt(1, 32'hDEADBEEF, 8'h78);
        fork
            request(0, 32'h12345678, 0);
            request(1, 32'hDEADBEEF, 0);
        join
        finish_test("tie", 1, 1, 2);
        check("tie_grant_b_last", grant_b, 1);

        // Fairness: A held high, B raised mid-packet.
        reset_dut();
        push_pkt(0, 32'h12345678, 8'hAD);
        push_pkt(1, 32'hDEADBEEF, 8'h78);
        push_pkt(0, 32'hCAFEF00D, 8'h6C);
        fork
            begin
                request(0, 32'h12345678, 1);
                request(0, 32'hCAFEF00D, 0);
            end
            begin
                repeat (20) @(negedge clk);
                request(1, 32'hDEADBEEF, 0);
            end
        join
        finish_test("fair", 2, 1, 3);

        // UART busy gating for 100 cycles at grant.
        reset_dut();
        force_busy = 1'b1;
        push_pkt(0, 32'h12345678, 8'hAD);
        request(0, 32'h12345678, 0);
        saw_tx = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (uart_transmit !== 1'b0) saw_tx = 1'b1;
        end
        check("gated_no_tx", saw_tx, 0);
        force_busy = 1'b0;
        @(negedge clk);
        check("gated_tx_after_fall", uart_transmit, 1);
        check("gated_first_byte", uart_tx_byte, 8'hA5);
        finish_test("gate", 1, 0, 1);

        // Stray done while parked in ISSUE.
        reset_dut();
        force_busy = 1'b1;
        push_pkt(0, 32'h0F0F0F0F, 8'hA5);
        request(0, 32'h0F0F0F0F, 0);
        repeat (3) @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        force_busy = 1'b0;
        finish_test("stray", 1, 0, 1);

        // Async reset right after byte 2 goes out.
        reset_dut();
        push_pkt(0, 32'h12345678, 8'hAD);
        request(0, 32'h12345678, 0);
        found = 1'b0;
        seen = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (uart_transmit === 1'b1) begin
                seen++;
                if (seen == 2) found = 1'b1;
            end
        end
        check("abort_second_byte_seen", found, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_transmit", uart_transmit, 0);
        check("abort_ack_a", ack_a, 0);
        check("abort_ack_b", ack_b, 0);
        check("abort_pkt_done", pkt_done, 0);
        exp_q.delete(); gb_q.delete();
        n_ack_a = 0; n_ack_b = 0; n_pkt = 0; n_tx = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        push_pkt(0, 32'hCAFEF00D, 8'h6C);
        request(0, 32'hCAFEF00D, 0);
        finish_test("restart", 1, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
